// File: rtl/vpu_controller_if.sv
// Bundles the decoder, SRF and execution-unit signals seen by vpu_controller.
// The master modport is the controller side; slave is its environment.
interface vpu_controller_if #(
   parameter int OPERAND_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH         = 256,
   parameter int OP_FUNC_WIDTH      = 13
) ();

   logic                          ctrl_valid_i;
   logic                          ctrl_ready_o;
   logic [2:0]                    instr_rvalid_i;
   logic [OPERAND_ADDR_WIDTH-1:0] instr_raddr0_i;
   logic [OPERAND_ADDR_WIDTH-1:0] instr_raddr1_i;
   logic [OPERAND_ADDR_WIDTH-1:0] instr_raddr2_i;
   logic [OPERAND_ADDR_WIDTH-1:0] instr_waddr_i;
   logic [OP_FUNC_WIDTH-1:0]      instr_op_func_i;

   logic                          rd_en_o;
   logic [OPERAND_ADDR_WIDTH-1:0] rd_addr_o;
   logic [DATA_WIDTH-1:0]         rd_data_i;

   logic                          exec_valid_o;
   logic                          exec_ready_i;
   logic [OP_FUNC_WIDTH-1:0]      exec_op_func_o;
   logic [DATA_WIDTH-1:0]         exec_src0_o;
   logic [DATA_WIDTH-1:0]         exec_src1_o;
   logic [DATA_WIDTH-1:0]         exec_src2_o;
   logic                          exec_done_i;
   logic [DATA_WIDTH-1:0]         exec_result_i;

   logic                          wr_en_o;
   logic [OPERAND_ADDR_WIDTH-1:0] wr_addr_o;
   logic [DATA_WIDTH-1:0]         wr_data_o;

   modport master (
      input  ctrl_valid_i, instr_rvalid_i, instr_raddr0_i, instr_raddr1_i,
             instr_raddr2_i, instr_waddr_i, instr_op_func_i,
             rd_data_i, exec_ready_i, exec_done_i, exec_result_i,
      output ctrl_ready_o, rd_en_o, rd_addr_o,
             exec_valid_o, exec_op_func_o, exec_src0_o, exec_src1_o, exec_src2_o,
             wr_en_o, wr_addr_o, wr_data_o
   );

   modport slave (
      output ctrl_valid_i, instr_rvalid_i, instr_raddr0_i, instr_raddr1_i,
             instr_raddr2_i, instr_waddr_i, instr_op_func_i,
             rd_data_i, exec_ready_i, exec_done_i, exec_result_i,
      input  ctrl_ready_o, rd_en_o, rd_addr_o,
             exec_valid_o, exec_op_func_o, exec_src0_o, exec_src1_o, exec_src2_o,
             wr_en_o, wr_addr_o, wr_data_o
   );

endinterface

// File: rtl/vpu_controller.sv
// Single-issue VPU sequencer: latch a decoded instruction, read its source
// operands from the SRF, hand it to the exec unit, then write the result back.
module vpu_controller #(
   parameter int OPERAND_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH         = 256,
   parameter int OP_FUNC_WIDTH      = 13,
   parameter int CNT_WIDTH          = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   vpu_controller_if.master     bus,
   output logic                 err_o,
   output logic [CNT_WIDTH-1:0] retired_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LATCH  = 3'd1,
      S_READ   = 3'd2,
      S_RDWAIT = 3'd3,
      S_EXEC   = 3'd4,
      S_WAIT   = 3'd5,
      S_WB     = 3'd6
   } state_e;

   state_e                        state_q, state_d;
   logic [OPERAND_ADDR_WIDTH-1:0] raddr0_q, raddr1_q, raddr2_q, waddr_q;
   logic [OP_FUNC_WIDTH-1:0]      op_func_q;
   logic [2:0]                    rem_q;
   logic                          cap_valid_q;
   logic [1:0]                    cap_idx_q;
   logic [DATA_WIDTH-1:0]         src0_q, src1_q, src2_q, result_q;
   logic [CNT_WIDTH-1:0]          retired_q;
   logic                          err_q;

   logic                          illegal_s;
   logic                          rd_last_s;
   logic [1:0]                    rd_idx_s;

   function automatic logic [1:0] lowest_src(input logic [2:0] mask);
      if (mask[0]) begin
         return 2'd0;
      end else if (mask[1]) begin
         return 2'd1;
      end else begin
         return 2'd2;
      end
   endfunction

   // Read-sequencing decode: rem_q holds the sources still to be issued.
   always_comb begin
      illegal_s = (bus.instr_op_func_i == {OP_FUNC_WIDTH{1'b0}});
      rd_idx_s  = lowest_src(rem_q);
      rd_last_s = ((rem_q & (rem_q - 3'd1)) == 3'b000);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ctrl_valid_i) begin
               state_d = S_LATCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LATCH: begin
            if (illegal_s) begin
               state_d = S_IDLE;
            end else if (bus.instr_rvalid_i == 3'b000) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (rd_last_s) begin
               state_d = S_RDWAIT;
            end else begin
               state_d = S_READ;
            end
         end
         S_RDWAIT: state_d = S_EXEC;
         S_EXEC: begin
            if (bus.exec_ready_i) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_WAIT: begin
            if (bus.exec_done_i) begin
               state_d = S_WB;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Instruction, operand, result and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raddr0_q    <= {OPERAND_ADDR_WIDTH{1'b0}};
         raddr1_q    <= {OPERAND_ADDR_WIDTH{1'b0}};
         raddr2_q    <= {OPERAND_ADDR_WIDTH{1'b0}};
         waddr_q     <= {OPERAND_ADDR_WIDTH{1'b0}};
         op_func_q   <= {OP_FUNC_WIDTH{1'b0}};
         rem_q       <= 3'b000;
         cap_valid_q <= 1'b0;
         cap_idx_q   <= 2'd0;
         src0_q      <= {DATA_WIDTH{1'b0}};
         src1_q      <= {DATA_WIDTH{1'b0}};
         src2_q      <= {DATA_WIDTH{1'b0}};
         result_q    <= {DATA_WIDTH{1'b0}};
         retired_q   <= {CNT_WIDTH{1'b0}};
         err_q       <= 1'b0;
      end else begin
         cap_valid_q <= 1'b0;
         err_q       <= (state_q == S_LATCH) && illegal_s;
         // SRF data lands one cycle after its read strobe.
         if (cap_valid_q) begin
            case (cap_idx_q)
               2'd0:    src0_q <= bus.rd_data_i;
               2'd1:    src1_q <= bus.rd_data_i;
               default: src2_q <= bus.rd_data_i;
            endcase
         end
         case (state_q)
            S_LATCH: begin
               raddr0_q  <= bus.instr_raddr0_i;
               raddr1_q  <= bus.instr_raddr1_i;
               raddr2_q  <= bus.instr_raddr2_i;
               waddr_q   <= bus.instr_waddr_i;
               op_func_q <= bus.instr_op_func_i;
               rem_q     <= bus.instr_rvalid_i;
               src0_q    <= {DATA_WIDTH{1'b0}};
               src1_q    <= {DATA_WIDTH{1'b0}};
               src2_q    <= {DATA_WIDTH{1'b0}};
            end
            S_READ: begin
               rem_q       <= rem_q & (rem_q - 3'd1);
               cap_valid_q <= 1'b1;
               cap_idx_q   <= rd_idx_s;
            end
            S_WAIT: begin
               if (bus.exec_done_i) begin
                  result_q <= bus.exec_result_i;
               end
            end
            S_WB: begin
               retired_q <= retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decoded from state and registers only.
   always_comb begin
      bus.ctrl_ready_o   = (state_q == S_IDLE);
      bus.rd_en_o        = (state_q == S_READ);
      bus.exec_valid_o   = (state_q == S_EXEC);
      bus.wr_en_o        = (state_q == S_WB);
      bus.rd_addr_o      = {OPERAND_ADDR_WIDTH{1'b0}};
      if (state_q == S_READ) begin
         case (rd_idx_s)
            2'd0:    bus.rd_addr_o = raddr0_q;
            2'd1:    bus.rd_addr_o = raddr1_q;
            default: bus.rd_addr_o = raddr2_q;
         endcase
      end else begin
         bus.rd_addr_o = {OPERAND_ADDR_WIDTH{1'b0}};
      end
      bus.exec_op_func_o = op_func_q;
      bus.exec_src0_o    = src0_q;
      bus.exec_src1_o    = src1_q;
      bus.exec_src2_o    = src2_q;
      bus.wr_addr_o      = waddr_q;
      bus.wr_data_o      = result_q;
      err_o              = err_q;
      retired_cnt_o      = retired_q;
   end

endmodule

// File: tb/tb_vpu_controller.sv
// Randomized bench for vpu_controller: an instruction-level model predicts the
// cycle-by-cycle strobes, read order, exec payload, write-back and counter.
module tb_vpu_controller;

   localparam int AW = 8;
   localparam int DW = 256;
   localparam int OW = 13;
   localparam int CW = 5;

   typedef logic [DW-1:0] word_t;
   typedef logic [AW-1:0] addr_t;
   typedef logic [OW-1:0] op_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vpu_controller_if #(.OPERAND_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OP_FUNC_WIDTH(OW)) bus ();
   logic          err;
   logic [CW-1:0] cnt;

   vpu_controller #(
      .OPERAND_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OP_FUNC_WIDTH(OW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .err_o(err), .retired_cnt_o(cnt)
   );

   int            total = 0;
   int            bad   = 0;
   word_t         mem [256];
   logic          rd_pend = 1'b0;
   addr_t         rd_pend_addr = '0;
   logic [CW-1:0] exp_cnt = '0;

   task automatic check_val(input string tag, input word_t obs, input word_t exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic word_t rand_word();
      word_t w;
      for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom();
      return w;
   endfunction

   // One cycle: advance past the edge, then answer the previous cycle's SRF read.
   task automatic step();
      @(posedge clk);
      #1;
      if (rd_pend) bus.rd_data_i = mem[rd_pend_addr];
      else         bus.rd_data_i = rand_word();
      rd_pend      = bus.rd_en_o;
      rd_pend_addr = bus.rd_addr_o;
   endtask

   task automatic junk_fields();
      bus.instr_rvalid_i  = 3'($urandom_range(0, 7));
      bus.instr_raddr0_i  = addr_t'($urandom());
      bus.instr_raddr1_i  = addr_t'($urandom());
      bus.instr_raddr2_i  = addr_t'($urandom());
      bus.instr_waddr_i   = addr_t'($urandom());
      bus.instr_op_func_i = op_t'($urandom());
   endtask

   task automatic run_instr(input logic [2:0] rv, input addr_t a0, input addr_t a1,
                            input addr_t a2, input addr_t wa, input op_t op,
                            input int rdy_dly, input int done_dly, input bit spur,
                            input bit hold);
      addr_t    aq [$];
      word_t    es [3];
      addr_t    ad [3];
      word_t    res;
      int       n, tx, e, d, last, guard;
      bit       illegal;
      logic [4:0] exp_s, obs_s;
      guard = 0;
      while (bus.ctrl_ready_o !== 1'b1 && guard < 40) begin
         step();
         guard++;
      end
      if (guard >= 40) begin
         check_val("ready_timeout", word_t'(bus.ctrl_ready_o), word_t'(1'b1));
         return;
      end
      ad[0] = a0; ad[1] = a1; ad[2] = a2;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         es[i] = rv[i] ? mem[ad[i]] : '0;
         if (rv[i]) begin
            aq.push_back(ad[i]);
            n++;
         end
      end
      illegal = (op == '0);
      tx   = 2 + n + ((n > 0) ? 1 : 0);
      e    = tx + rdy_dly;
      d    = e + done_dly;
      last = illegal ? 2 : d + 2;
      res  = rand_word();

      bus.ctrl_valid_i = 1'b1;
      junk_fields();
      for (int t = 0; t <= last; t++) begin
         if (t > 0) begin
            step();
            exp_s[4] = (t == last);
            exp_s[3] = !illegal && t >= 2 && t < 2 + n;
            exp_s[2] = !illegal && t >= tx && t <= e;
            exp_s[1] = !illegal && t == d + 1;
            exp_s[0] = illegal && t == 2;
            obs_s = {bus.ctrl_ready_o, bus.rd_en_o, bus.exec_valid_o, bus.wr_en_o, err};
            check_val("strobes", word_t'(obs_s), word_t'(exp_s));
            if (exp_s[3] && (t - 2) < aq.size())
               check_val("rd_addr", word_t'(bus.rd_addr_o), word_t'(aq[t-2]));
            if (exp_s[2]) begin
               check_val("exec_op", word_t'(bus.exec_op_func_o), word_t'(op));
               check_val("exec_src0", bus.exec_src0_o, es[0]);
               check_val("exec_src1", bus.exec_src1_o, es[1]);
               check_val("exec_src2", bus.exec_src2_o, es[2]);
            end
            if (exp_s[1]) begin
               check_val("wr_addr", word_t'(bus.wr_addr_o), word_t'(wa));
               check_val("wr_data", bus.wr_data_o, res);
            end
            if (t == last && !illegal) exp_cnt = exp_cnt + 1'b1;
            check_val("retired_cnt", word_t'(cnt), word_t'(exp_cnt));
         end
         if (t == 1) begin
            bus.instr_rvalid_i  = rv;
            bus.instr_raddr0_i  = a0;
            bus.instr_raddr1_i  = a1;
            bus.instr_raddr2_i  = a2;
            bus.instr_waddr_i   = wa;
            bus.instr_op_func_i = op;
            bus.ctrl_valid_i    = hold;
         end
         bus.exec_ready_i  = !illegal && t == e;
         bus.exec_done_i   = !illegal && ((t == d) || (spur && t >= tx && t <= e));
         bus.exec_result_i = (t == d) ? res : rand_word();
      end
      bus.ctrl_valid_i = hold;
      bus.exec_done_i  = 1'b0;
      bus.exec_ready_i = 1'b0;
   endtask

   task automatic reset_mid_exec();
      int guard = 0;
      while (bus.ctrl_ready_o !== 1'b1 && guard < 40) begin
         step();
         guard++;
      end
      bus.ctrl_valid_i = 1'b1;
      junk_fields();
      step();
      bus.ctrl_valid_i    = 1'b0;
      bus.instr_rvalid_i  = 3'b000;
      bus.instr_op_func_i = 13'h001;
      bus.exec_ready_i    = 1'b0;
      step();
      check_val("rst_pre_exec_valid", word_t'(bus.exec_valid_o), word_t'(1'b1));
      rst_n = 1'b0;
      #1;
      check_val("rst_exec_valid", word_t'(bus.exec_valid_o), word_t'(1'b0));
      check_val("rst_ready", word_t'(bus.ctrl_ready_o), word_t'(1'b1));
      check_val("rst_cnt", word_t'(cnt), word_t'(0));
      exp_cnt = '0;
      step();
      step();
      rst_n = 1'b1;
      rd_pend = 1'b0;
      for (int k = 0; k < 6; k++) begin
         bus.exec_ready_i  = 1'b1;
         bus.exec_done_i   = 1'b1;
         bus.exec_result_i = rand_word();
         step();
         check_val("rst_no_wr", word_t'({bus.wr_en_o, bus.ctrl_ready_o}), word_t'(2'b01));
         check_val("rst_cnt_hold", word_t'(cnt), word_t'(exp_cnt));
      end
      bus.exec_ready_i = 1'b0;
      bus.exec_done_i  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bit prev_hold;
      bit hold;
      for (int i = 0; i < 256; i++) mem[i] = rand_word();
      bus.ctrl_valid_i  = 1'b0;
      bus.exec_ready_i  = 1'b0;
      bus.exec_done_i   = 1'b0;
      bus.exec_result_i = '0;
      bus.rd_data_i     = '0;
      junk_fields();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_val("reset_strobes",
                word_t'({bus.ctrl_ready_o, bus.rd_en_o, bus.exec_valid_o, bus.wr_en_o, err}),
                word_t'(5'b10000));
      check_val("reset_cnt", word_t'(cnt), word_t'(0));
      step();
      rst_n = 1'b1;
      step();

      run_instr(3'b011, 8'h10, 8'h11, 8'h5a, 8'h20, 13'h004, 0, 1, 1'b0, 1'b0); // FADD
      run_instr(3'b111, 8'h30, 8'h31, 8'h32, 8'h40, 13'h005, 5, 2, 1'b1, 1'b0); // FADD3
      run_instr(3'b001, 8'h50, 8'h77, 8'h78, 8'h60, 13'h040, 1, 3, 1'b0, 1'b0); // FSQRT
      run_instr(3'b111, 8'h01, 8'h02, 8'h03, 8'h04, 13'h000, 0, 1, 1'b0, 1'b0); // illegal
      run_instr(3'b000, 8'h00, 8'h00, 8'h00, 8'h0f, 13'h1ff, 0, 1, 1'b0, 1'b0);
      reset_mid_exec();

      prev_hold = 1'b0;
      for (int i = 0; i < 48; i++) begin
         hold = (i >= 10 && i < 30);
         if (!prev_hold) repeat ($urandom_range(0, 2)) step();
         run_instr(3'($urandom_range(0, 7)), addr_t'($urandom()), addr_t'($urandom()),
                   addr_t'($urandom()), addr_t'($urandom()),
                   ($urandom_range(0, 7) == 0) ? op_t'(0) : op_t'($urandom_range(1, 8191)),
                   $urandom_range(0, 3), $urandom_range(1, 3),
                   1'($urandom_range(0, 1)), hold);
         prev_hold = hold;
      end
      bus.ctrl_valid_i = 1'b0;
      repeat (3) step();
      check_val("final_idle_ready", word_t'(bus.ctrl_ready_o), word_t'(1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
